// File: rtl/ifu_fetch.sv
// Instruction fetch unit: single-outstanding fetch requests feeding a FIFO to decode.
// Optional macro IFU_PERF_CNT_EN adds the o_perf_fetch_cnt pop counter.
module ifu_fetch #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned            QUEUE_DEPTH = 4
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                  i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
  input  logic                  i_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_jmp_pc,
  output logic                  o_inst_valid,
  input  logic                  i_inst_ready,
  output logic [DATA_WIDTH-1:0] o_inst_data,
  output logic [ADDR_WIDTH-1:0] o_inst_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           o_perf_fetch_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  req_vld_q, req_vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] q_data_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_q   [QUEUE_DEPTH];
  logic                  fire;
  logic                  push;
  logic                  pop;

  // A redirect in the current cycle suppresses the registered request intent.
  assign o_mem_req_valid = req_vld_q && !i_jmp_en;
  assign o_mem_req_addr  = pc_q;
  assign o_inst_valid    = (cnt_q != '0);
  assign o_inst_data     = q_data_q[rd_ptr_q];
  assign o_inst_pc       = q_pc_q[rd_ptr_q];
  assign fire            = o_mem_req_valid && i_mem_req_ready;
  assign pop             = o_inst_valid && i_inst_ready && !i_jmp_en;

  // Next-state for the fetch FSM, PC and queue bookkeeping.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    push     = 1'b0;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_jmp_en) begin
          pc_d = i_jmp_pc;
        end else if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_WIDTH'(4);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_jmp_en) pc_d = i_jmp_pc;
        if (i_mem_resp_valid) begin
          push    = !i_jmp_en;
          state_d = ST_IDLE;
        end else if (i_jmp_en) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (i_jmp_en) pc_d = i_jmp_pc;
        if (i_mem_resp_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_jmp_en) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    req_vld_d = (state_d == ST_IDLE) && (cnt_d < CNT_W'(QUEUE_DEPTH));
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      req_vld_q <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      req_vld_q <= req_vld_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Queue storage is reset so the head reads zero out of reset.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else if (push) begin
      q_data_q[wr_ptr_q] <= i_mem_resp_data;
      q_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  assign perf_cnt_d       = perf_cnt_q + 32'(pop);
  assign o_perf_fetch_cnt = perf_cnt_q;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) perf_cnt_q <= '0;
    else              perf_cnt_q <= perf_cnt_d;
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, async reset check, and randomized
// traffic against a queue-based reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        jmp_en;
  logic [31:0] jmp_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .o_mem_req_valid (req_valid),
    .i_mem_req_ready (req_ready),
    .o_mem_req_addr  (req_addr),
    .i_mem_resp_valid(resp_valid),
    .i_mem_resp_data (resp_data),
    .i_jmp_en        (jmp_en),
    .i_jmp_pc        (jmp_pc),
    .o_inst_valid    (inst_valid),
    .i_inst_ready    (inst_ready),
    .o_inst_data     (inst_data),
    .o_inst_pc       (inst_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt(perf_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        jen;
    logic [31:0] jpc;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_idata;
  } vec_t;

  vec_t vecs[12];

  // Reference model: instruction queue, fetch PC and outstanding-request flags.
  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_outst;
  bit          m_stale;
  bit          m_armed;
  logic [31:0] m_perf;

  task automatic model_reset();
    mq.delete();
    m_pc     = RST_PC;
    m_req_pc = RST_PC;
    m_outst  = 0;
    m_stale  = 0;
    m_armed  = 0;
    m_perf   = 0;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic jen, input logic [31:0] jpc, input logic irdy);
    req_ready  = rdy;
    resp_valid = rv;
    resp_data  = rdata;
    jmp_en     = jen;
    jmp_pc     = jpc;
    inst_ready = irdy;
  endtask

  // One model-checked cycle: drive, compare at negedge, advance the model, cross posedge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] rdata,
                      input logic jen, input logic [31:0] jpc, input logic irdy);
    bit   e_rv, e_iv, fire, pop;
    ent_t e;
    drive(rdy, rv, rdata, jen, jpc, irdy);
    @(negedge clk);
    e_rv = m_armed && !m_outst && (mq.size() < DEPTH) && !jen;
    e_iv = (mq.size() != 0);
    chk("req_valid", 32'(req_valid), 32'(e_rv));
    chk("req_addr", req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(e_iv));
    if (e_iv) begin
      chk("inst_pc", inst_pc, mq[0].pc);
      chk("inst_data", inst_data, mq[0].d);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_cnt", perf_cnt, m_perf);
`endif
    fire = e_rv && rdy;
    pop  = e_iv && irdy && !jen;
    if (m_outst && rv) begin
      if (!m_stale && !jen) begin
        e.d  = rdata;
        e.pc = m_req_pc;
        mq.push_back(e);
      end
      m_outst = 0;
      m_stale = 0;
    end else if (m_outst && jen) begin
      m_stale = 1;
    end
    if (jen) begin
      mq.delete();
      m_pc = jpc;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        m_perf++;
      end
      if (fire) begin
        m_req_pc = m_pc;
        m_pc     = m_pc + 32'd4;
        m_outst  = 1;
      end
    end
    m_armed = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", req_addr, RST_PC);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rst_perf_cnt", perf_cnt, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] d0, d1, d2, d3, junk;
    d0 = 32'h1111_0000; d1 = 32'h2222_0004; d2 = 32'h3333_0008;
    d3 = 32'h4444_FFFC; junk = 32'hBAD0_BAD0;

    vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         32'h0};
    vecs[2]  = '{1'b1, 1'b1, d0,    1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0004, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 1'b1, junk,  1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000, d0};
    vecs[4]  = '{1'b1, 1'b1, d1,    1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_0008, 1'b0, 32'h0,         32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0004, d1};
    vecs[6]  = '{1'b1, 1'b1, d2,    1'b0, 32'h0,         1'b1, 1'b0, 32'h8000_000C, 1'b0, 32'h0,         32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h8000_000C, 1'b1, 32'h8000_0008, d2};
    vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 1'b1, d3,    1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, d3};
    vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, d3};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    // Directed table: in-order fetch, ignored IDLE response, jump to top of memory, wrap, stall.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rdata, vecs[i].jen, vecs[i].jpc, vecs[i].irdy);
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), 32'(req_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_req_addr", i), req_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
        chk($sformatf("vec%0d_inst_data", i), inst_data, vecs[i].e_idata);
      end
      @(posedge clk);
      #1;
    end

    // Fire one request with a queued entry, then reset asynchronously mid-WAIT.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    model_reset();

    // Fill the queue with decode stalled, then release a single pop.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'hA100_0000, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'hA200_0000 + 32'(i), 1'b0, 32'h0, 1'b0);

    // Redirect while a request is outstanding, stale response three cycles later.
    for (int i = 0; i < 10 && !m_outst; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0100, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 32'h0, 1'b1);

    // Memory not ready for five cycles: request and address must hold.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        jen;
      logic [31:0] jpc;
      jen = ($urandom_range(0, 15) == 0);
      jpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom, jen, jpc, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
